// File: rtl/display_scan4.sv
// rtl/display_scan4.sv - four-digit time-multiplexed display scanner with frame snapshot and leading-zero blanking
module display_scan4 #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_en,
    input  logic        blank_lz,
    output logic [3:0]  digit_sel,
    output logic [3:0]  bcd_out,
    output logic        blank,
    output logic        dp,
    output logic        frame_tick
);

    localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [DIV_W-1:0] div;
    logic [1:0]       idx;
    logic [15:0]      snap_digits;
    logic [3:0]       snap_dp;
    logic             snap_lz;
    logic             load_pending;
    logic             frame_tick_q;

    logic             div_last;
    logic             frame_wrap;
    logic             upper_zero;

    assign div_last   = (div == DIV_LAST);
    assign frame_wrap = div_last && (idx == 2'd3);

    // Divider and digit index: each digit dwells REFRESH_DIV cycles, then the index steps.
    always_ff @(posedge clk) begin
        if (!reset) begin
            div <= '0;
            idx <= 2'd0;
        end else if (div_last) begin
            div <= '0;
            idx <= idx + 2'd1;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // Snapshot loads on the frame wrap, or once right after reset without touching the scan position.
    always_ff @(posedge clk) begin
        if (!reset) begin
            snap_digits  <= '0;
            snap_dp      <= '0;
            snap_lz      <= 1'b0;
            load_pending <= 1'b1;
        end else begin
            if (frame_wrap || load_pending) begin
                snap_digits <= digits;
                snap_dp     <= dp_en;
                snap_lz     <= blank_lz;
            end
            load_pending <= 1'b0;
        end
    end

    // Frame tick is high for exactly the first cycle of each new frame; the post-reset load never raises it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= frame_wrap;
        end
    end

    // A digit is blank when it and every more-significant snapshot digit are zero; A-F counts as non-zero.
    always_comb begin
        upper_zero = 1'b1;
        for (int j = 0; j < 4; j++) begin
            if ((j >= int'(idx)) && (snap_digits[4*j +: 4] != 4'd0)) begin
                upper_zero = 1'b0;
            end
        end
        blank = snap_lz && (idx != 2'd0) && upper_zero;
    end

    // Digit mux and select decode, straight from registered state.
    always_comb begin
        digit_sel = 4'b0001;
        bcd_out   = snap_digits[3:0];
        case (idx)
            2'd0: begin
                digit_sel = 4'b0001;
                bcd_out   = snap_digits[3:0];
            end
            2'd1: begin
                digit_sel = 4'b0010;
                bcd_out   = snap_digits[7:4];
            end
            2'd2: begin
                digit_sel = 4'b0100;
                bcd_out   = snap_digits[11:8];
            end
            default: begin
                digit_sel = 4'b1000;
                bcd_out   = snap_digits[15:12];
            end
        endcase
    end

    assign dp         = snap_dp[idx] & ~blank;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan4.sv
// tb/tb_display_scan4.sv - scoreboard bench for display_scan4 with REFRESH_DIV=4
module tb_display_scan4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits;
    logic [3:0]  dp_en;
    logic        blank_lz;
    logic [3:0]  digit_sel;
    logic [3:0]  bcd_out;
    logic        blank;
    logic        dp;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;

    // {digit_sel, bcd_out, blank, dp, frame_tick}
    logic [10:0] exp_q[$];

    display_scan4 #(.REFRESH_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .digits     (digits),
        .dp_en      (dp_en),
        .blank_lz   (blank_lz),
        .digit_sel  (digit_sel),
        .bcd_out    (bcd_out),
        .blank      (blank),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic exp_blank(input logic [15:0] d, input int i, input logic lz);
        logic z;
        z = 1'b1;
        for (int j = i; j < 4; j++) begin
            if (d[4*j +: 4] != 4'd0) z = 1'b0;
        end
        return lz && (i != 0) && z;
    endfunction

    // Drives one frame's inputs, queues its expected cycles first..last, then drains and compares each cycle.
    // Called at a negedge; the inputs set here are loaded by the next posedge.
    task automatic run_frame(input string name, input logic [15:0] d, input logic [3:0] dpe,
                             input logic lz, input int first, input int last,
                             input int mid_at, input logic [15:0] mid_d);
        logic [10:0] e;
        logic [10:0] got;
        logic        b;
        digits   = d;
        dp_en    = dpe;
        blank_lz = lz;
        for (int k = first; k <= last; k++) begin
            int i;
            i = k / 4;
            b = exp_blank(d, i, lz);
            e = {4'(1 << i), d[4*i +: 4], b, dpe[i] & ~b, (k == 0)};
            exp_q.push_back(e);
        end
        for (int k = first; k <= last; k++) begin
            @(negedge clk);
            got = {digit_sel, bcd_out, blank, dp, frame_tick};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL %s cycle %0d: scoreboard empty, got %b", name, k, got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    bad++;
                    $display("FAIL %s cycle %0d: got sel=%b bcd=%h blank=%b dp=%b tick=%b, want sel=%b bcd=%h blank=%b dp=%b tick=%b",
                             name, k, got[10:7], got[6:3], got[2], got[1], got[0],
                             e[10:7], e[6:3], e[2], e[1], e[0]);
                end
            end
            if (k == mid_at) digits = mid_d;
        end
    endtask

    task automatic test_reset;
        reset    = 1'b0;
        digits   = 16'h9876;
        dp_en    = 4'b0000;
        blank_lz = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (digit_sel !== 4'b0001) begin bad++; $display("FAIL reset_sel: got %b want 0001", digit_sel); end
        total++; if (bcd_out !== 4'h0) begin bad++; $display("FAIL reset_bcd: got %h want 0", bcd_out); end
        total++; if (blank !== 1'b0) begin bad++; $display("FAIL reset_blank: got %b want 0", blank); end
        total++; if (dp !== 1'b0) begin bad++; $display("FAIL reset_dp: got %b want 0", dp); end
        total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", frame_tick); end
        reset = 1'b1;
        run_frame("post_reset", 16'h9876, 4'b0000, 1'b0, 1, 15, -1, 16'h0);
    endtask

    task automatic test_scan_order;
        run_frame("scan_a", 16'h1234, 4'b0100, 1'b0, 0, 15, -1, 16'h0);
        run_frame("scan_b", 16'h1234, 4'b0100, 1'b0, 0, 15, -1, 16'h0);
    endtask

    task automatic test_blanking;
        run_frame("lz_0050", 16'h0050, 4'b1111, 1'b1, 0, 15, -1, 16'h0);
        run_frame("lz_0000", 16'h0000, 4'b1111, 1'b1, 0, 15, -1, 16'h0);
        run_frame("lz_off_0000", 16'h0000, 4'b0000, 1'b0, 0, 15, -1, 16'h0);
    endtask

    task automatic test_snapshot;
        run_frame("snap_hold", 16'h1234, 4'b0000, 1'b0, 0, 15, 5, 16'h5678);
        run_frame("snap_next", 16'h5678, 4'b0000, 1'b0, 0, 15, -1, 16'h0);
    endtask

    task automatic test_non_bcd;
        run_frame("non_bcd", 16'h00A0, 4'b0000, 1'b1, 0, 15, -1, 16'h0);
        run_frame("non_bcd_top", 16'hF000, 4'b0000, 1'b1, 0, 15, -1, 16'h0);
    endtask

    task automatic test_mid_reset;
        run_frame("pre_reset", 16'h1234, 4'b0001, 1'b0, 0, 9, -1, 16'h0);
        reset = 1'b0;
        @(negedge clk);
        total++; if (digit_sel !== 4'b0001) begin bad++; $display("FAIL mid_reset_sel: got %b want 0001", digit_sel); end
        total++; if (bcd_out !== 4'h0) begin bad++; $display("FAIL mid_reset_bcd: got %h want 0", bcd_out); end
        total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL mid_reset_tick: got %b want 0", frame_tick); end
        reset = 1'b1;
        run_frame("after_mid_reset", 16'h4321, 4'b0010, 1'b0, 1, 15, -1, 16'h0);
        run_frame("resumed", 16'h4321, 4'b0010, 1'b0, 0, 15, -1, 16'h0);
    endtask

    initial begin
        test_reset;
        test_scan_order;
        test_blanking;
        test_snapshot;
        test_non_bcd;
        test_mid_reset;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_left: got %0d entries want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/display_scan4.md
# display_scan4

Four-digit time-multiplexed display scanner for the counter/display chain. It sits downstream of the cascaded decade counters and upstream of the BCD-to-7-segment decoder. Each cycle it selects one of four BCD digits, presents it to a single shared decoder, and drives a one-hot digit-select bus. It applies leading-zero blanking and latches the digit bus once per frame so a frame never mixes values from two counter states.

## Interface

Parameters:
- REFRESH_DIV, default 50000: clock cycles each digit stays selected. Legal values are 2 or more. Divider width is clog2(REFRESH_DIV).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- digits  input  16  four BCD digits; [3:0] is digit 0 (least significant), [15:12] is digit 3.
- dp_en  input  4  decimal-point request per digit; bit i belongs to digit i.
- blank_lz  input  1  1 = enable leading-zero blanking.
- digit_sel  output  4  one-hot, active-high digit enable; bit i selects digit i.
- bcd_out  output  4  BCD value of the selected digit; feeds the decoder.
- blank  output  1  1 = selected digit must be dark; downstream gates all segments.
- dp  output  1  decimal point for the selected digit.
- frame_tick  output  1  one-cycle pulse marking the start of a new frame.

## Operation

- State:
  - divider div, range 0..REFRESH_DIV-1.
  - digit index idx, range 0..3.
  - snapshot registers snap_digits[15:0], snap_dp[3:0], snap_lz.
  - load_pending flag.
  - frame_tick register.
- Divider: increments every cycle. At REFRESH_DIV-1 it wraps to 0 and idx advances.
- Digit order: idx advances 0→1→2→3→0. A frame is 4·REFRESH_DIV cycles.
- Frame snapshot:
  - On the edge where idx wraps 3→0, snap_digits, snap_dp and snap_lz load from digits, dp_en and blank_lz sampled on that edge.
  - Input changes at any other time have no visible effect until the next wrap.
- Post-reset load:
  - Reset sets load_pending=1.
  - On the first edge with reset=1, the snapshot loads from the inputs and load_pending clears.
  - idx and div are not disturbed by this load, and it does not raise frame_tick.
- Outputs are combinational from registered state only; no input-to-output path exists.
  - digit_sel = one-hot(idx).
  - bcd_out = snap_digits[4·idx+3 : 4·idx].
  - dp = snap_dp[idx] AND NOT blank.
- Leading-zero blanking:
  - blank=1 only when snap_lz=1, idx≠0, and every snapshot digit j with idx ≤ j ≤ 3 equals 0.
  - Digit 0 is never blanked.
  - A non-BCD value (A–F) counts as non-zero: it is passed to the decoder unmodified and is not blanked.
- frame_tick: register set to 1 on the 3→0 wrap edge, cleared on the next edge. It is high for exactly the first cycle of each new frame.

## Timing

- Reset values (one edge after reset=0 is sampled):
  - div=0, idx=0, snapshot all 0, load_pending=1.
  - digit_sel=4'b0001, bcd_out=0, blank=0, dp=0, frame_tick=0.
- Reset mid-frame: at the next edge, state returns to reset values regardless of idx or div. The scan restarts at digit 0 with a full REFRESH_DIV dwell.
- After reset release:
  - Digit 0 dwells REFRESH_DIV cycles, counted from the first edge with reset=1.
  - During the first of those cycles, outputs reflect the zeroed snapshot. From the second cycle on, they reflect the loaded snapshot.
- Output latency: digit_sel, bcd_out, blank and dp change in the same cycle idx changes, with no additional pipeline stage.
- Wrap edge: the idx change, the snapshot load and the frame_tick assertion all happen on one edge. The new digit 0 value is visible in the first cycle of the new frame.
- REFRESH_DIV=2 is legal: each digit is shown for 2 cycles and the frame is 8 cycles.

## Test plan

All scenarios use REFRESH_DIV=4.

1. Reset check: hold reset=0 for 3 edges with digits=16'h9876 → digit_sel=0001, bcd_out=0, blank=0, dp=0, frame_tick=0. Release reset → bcd_out=6 from the second cycle.
2. Scan order: digits=16'h1234, blank_lz=0, dp_en=4'b0100.
   - digit_sel walks 0001/0010/0100/1000, 4 cycles each, with bcd_out 4,3,2,1.
   - dp=1 only while digit_sel=0100.
   - frame_tick pulses every 16 cycles.
3. Leading-zero blanking, blank_lz=1:
   - digits=16'h0050 → digits 3 and 2 blank=1; digit 1 shows bcd_out=5, blank=0; digit 0 shows 0, blank=0.
   - digits=16'h0000 → only digit 0 is unblanked.
4. Snapshot coherence: with 16'h1234 latched, change digits to 16'h5678 during the idx=1 dwell → remainder of the frame shows 3,2,1. The next frame starts with 8, in the cycle frame_tick=1.
5. Non-BCD handling: blank_lz=1, digits=16'h00A0 → digit 1 shows bcd_out=4'hA with blank=0; digits 3 and 2 are blanked.
6. Mid-frame reset: assert reset=0 for one edge while idx=2, div=1 → next cycle digit_sel=0001, bcd_out=0. Digit 0 then dwells a full 4 cycles after release.
